// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: FSM states, FIFO byte width
// and the lane-mask helper.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int FIFO_DW = 8;

    // n low bits set; n in 0..8 covers every legal word width.
    function automatic logic [7:0] keep_mask(input int unsigned n);
        logic [8:0] full;
        full = (9'd1 << n) - 9'd1;
        return full[7:0];
    endfunction

endpackage

// File: rtl/fifo_drain_packer_if.sv
// FIFO read port plus the packed-word output stream. out_valid/out_ready: a word
// transfers on an edge where both are 1; once raised, out_valid and the word stay put until then.
interface fifo_drain_packer_if #(
    parameter int BYTES = 4
);
    logic [7:0]         fifo_data;
    logic               fifo_empty;
    logic               fifo_rn;
    logic               flush;
    logic [8*BYTES-1:0] out_data;
    logic [BYTES-1:0]   out_keep;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  fifo_data, fifo_empty, flush, out_ready,
        output fifo_rn, out_data, out_keep, out_valid
    );

    modport slave (
        output fifo_data, fifo_empty, flush, out_ready,
        input  fifo_rn, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/fifo_idle_timer.sv
// Saturating idle-cycle counter; expire_o marks the cycle that completes the
// TIMEOUT-th consecutive enabled cycle.
module fifo_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CW'(TIMEOUT))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_drain_packer.sv
// Pops bytes from a show-ahead FIFO and packs them little-endian into BYTES-wide
// words, emitting partial words on flush or after an idle timeout.
module fifo_drain_packer
    import fifo_pkg::*;
#(
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    fifo_drain_packer_if.master  bus,
    output logic [15:0]          word_count,
    output state_e               state_o
);
    localparam int IW = $clog2(BYTES + 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [8*BYTES-1:0] data_q, data_d;
    logic [15:0]        word_count_q, word_count_d;
    logic [IW-1:0]      idx_inc;
    logic [7:0]         keep_full;
    logic               pop;
    logic               idle;
    logic               expire;

    // Popped bytes are gone from the FIFO, so reset must also block the strobe.
    assign pop  = (state_q == FILL) && !bus.fifo_empty && !reset;
    assign idle = (state_q == FILL) && (idx_q != '0) && bus.fifo_empty;

    fifo_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (!idle),
        .enable_i (idle),
        .expire_o (expire)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        data_d       = data_q;
        word_count_d = word_count_q;
        idx_inc      = idx_q + IW'(pop);
        case (state_q)
            FILL: begin
                for (int k = 0; k < BYTES; k++) begin
                    if (pop && (idx_q == IW'(k))) begin
                        data_d[8*k +: 8] = bus.fifo_data;
                    end
                end
                idx_d = idx_inc;
                if ((idx_inc == IW'(BYTES)) || (bus.flush && (idx_inc != '0)) || expire) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d      = FILL;
                    idx_d        = '0;
                    data_d       = '0;
                    word_count_d = word_count_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            idx_q        <= '0;
            data_q       <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            word_count_q <= word_count_d;
        end
    end

    // While filling, the stream shows nothing; lanes above idx are already zero.
    assign keep_full     = keep_mask(32'(idx_q));
    assign bus.fifo_rn   = pop;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = (state_q == HOLD) ? data_q : '0;
    assign bus.out_keep  = (state_q == HOLD) ? keep_full[BYTES-1:0] : '0;
    assign word_count    = word_count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: a queue-backed show-ahead FIFO feeds the DUT and a
// byte-list reference model predicts every word, keep mask and handshake.
module tb_fifo_drain_packer;
    import fifo_pkg::*;

    localparam int BYTES   = 4;
    localparam int TIMEOUT = 16;
    localparam int W       = 8 * BYTES;

    logic        clock;
    logic        reset;
    logic [15:0] word_count;
    state_e      dbg_state;

    fifo_drain_packer_if #(.BYTES(BYTES)) bus ();

    fifo_drain_packer #(
        .BYTES   (BYTES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .word_count (word_count),
        .state_o    (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]       fifo_q[$];
    logic [7:0]       cur_q[$];
    logic [W-1:0]     exp_q[$];
    logic [BYTES-1:0] exp_keep_q[$];
    logic             m_hold;
    int               m_idle;
    logic [15:0]      m_wc;
    logic [W-1:0]     last_data;
    logic [BYTES-1:0] last_keep;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur_q.delete();
        exp_q.delete();
        exp_keep_q.delete();
        m_hold = 1'b0;
        m_idle = 0;
        m_wc   = 16'd0;
    endtask

    // Close the current byte list into one expected word.
    task automatic model_emit();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < cur_q.size(); k++) begin
            w = w | (W'(cur_q[k]) << (8 * k));
        end
        exp_q.push_back(w);
        exp_keep_q.push_back(BYTES'((1 << cur_q.size()) - 1));
        cur_q.delete();
        m_hold = 1'b1;
        m_idle = 0;
    endtask

    task automatic cycle(input logic fl, input logic rdy);
        logic rn_s;
        logic empty_s;
        @(negedge clock);
        bus.flush      = fl;
        bus.out_ready  = rdy;
        empty_s        = (fifo_q.size() == 0);
        bus.fifo_empty = empty_s;
        bus.fifo_data  = empty_s ? 8'h00 : fifo_q[0];
        #1;
        rn_s = bus.fifo_rn;
        check("out_valid", 64'(bus.out_valid), 64'(m_hold));
        check("fifo_rn", 64'(rn_s), 64'(!m_hold && !empty_s));
        check("state_dbg", 64'(dbg_state == HOLD), 64'(m_hold));
        check("word_count", 64'(word_count), 64'(m_wc));
        if (m_hold) begin
            check("out_data", 64'(bus.out_data), 64'(exp_q[0]));
            check("out_keep", 64'(bus.out_keep), 64'(exp_keep_q[0]));
        end else begin
            check("out_data_idle", 64'(bus.out_data), 64'd0);
            check("out_keep_idle", 64'(bus.out_keep), 64'd0);
        end
        if (m_hold) begin
            if (rdy) begin
                last_data = exp_q.pop_front();
                last_keep = exp_keep_q.pop_front();
                m_hold    = 1'b0;
                m_wc      = m_wc + 16'd1;
            end
        end else begin
            if (!empty_s) begin
                cur_q.push_back(fifo_q[0]);
                m_idle = 0;
            end else if (cur_q.size() > 0) begin
                m_idle++;
            end
            if ((cur_q.size() == BYTES) || (fl && cur_q.size() > 0) || (m_idle == TIMEOUT)) begin
                model_emit();
            end
        end
        @(posedge clock);
        #1;
        if (rn_s && !empty_s) void'(fifo_q.pop_front());
    endtask

    task automatic cycles(input int n, input logic fl, input logic rdy);
        for (int i = 0; i < n; i++) cycle(fl, rdy);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_keep", 64'(bus.out_keep), 64'd0);
        check("rst_rn", 64'(bus.fifo_rn), 64'd0);
        check("rst_wc", 64'(word_count), 64'd0);
        model_clear();
        bus.fifo_empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.fifo_data  = 8'h00;
        bus.fifo_empty = 1'b1;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        model_clear();
        last_data = '0;
        last_keep = '0;
        #12;
        check("init_valid", 64'(bus.out_valid), 64'd0);
        check("init_wc", 64'(word_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Full word with the consumer always ready.
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        cycles(6, 1'b0, 1'b1);
        check("full_data", 64'(last_data), 64'h44332211);
        check("full_keep", 64'(last_keep), 64'hF);
        check("full_wc", 64'(word_count), 64'd1);

        // Backpressure: two words queued, consumer stalled.
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        cycles(10, 1'b0, 1'b0);
        check("bp_hold_data", 64'(bus.out_data), 64'h04030201);
        check("bp_hold_rn", 64'(bus.fifo_rn), 64'd0);
        cycle(1'b0, 1'b1);
        check("bp_word1", 64'(last_data), 64'h04030201);
        cycles(6, 1'b0, 1'b1);
        check("bp_word2", 64'(last_data), 64'h08070605);
        check("bp_wc", 64'(word_count), 64'd3);

        // Timeout: two bytes then silence.
        fifo_q = '{8'hAA, 8'hBB};
        cycles(17, 1'b0, 1'b0);
        check("to_early", 64'(bus.out_valid), 64'd0);
        cycle(1'b0, 1'b0);
        check("to_valid", 64'(bus.out_valid), 64'd1);
        check("to_data", 64'(bus.out_data), 64'h0000BBAA);
        check("to_keep", 64'(bus.out_keep), 64'h3);
        cycles(2, 1'b0, 1'b1);

        // Flush on the same edge as the third pop.
        fifo_q = '{8'h10, 8'h20};
        cycles(2, 1'b0, 1'b0);
        fifo_q.push_back(8'h30);
        cycle(1'b1, 1'b0);
        check("fl_keep", 64'(bus.out_keep), 64'h7);
        check("fl_data", 64'(bus.out_data), 64'h00302010);
        cycles(2, 1'b0, 1'b1);

        // Flush with nothing buffered is ignored.
        cycles(3, 1'b1, 1'b1);
        check("fl0_valid", 64'(bus.out_valid), 64'd0);
        check("fl0_wc", 64'(word_count), 64'd5);

        // Reset with two bytes already popped.
        fifo_q = '{8'hE1, 8'hE2};
        cycles(2, 1'b0, 1'b1);
        do_reset();
        fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        cycles(6, 1'b0, 1'b1);
        check("rst_word", 64'(last_data), 64'hC4C3C2C1);
        check("rst_word_wc", 64'(word_count), 64'd1);

        // Randomized phases: dense, medium and sparse traffic.
        for (int ph = 0; ph < 9; ph++) begin
            int push_pct;
            case (ph % 3)
                0:       push_pct = 85;
                1:       push_pct = 40;
                default: push_pct = 4;
            endcase
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 99) < push_pct && fifo_q.size() < 16) begin
                    fifo_q.push_back(8'($urandom_range(0, 255)));
                end
                cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
            end
        end
        fifo_q.delete();
        cycles(TIMEOUT + 4, 1'b0, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
